// File: rtl/result_display.sv
// Double-dabble BCD converter for a 32-bit result or 16-bit remainder, driving a
// multiplexed 8-digit common-anode 7-segment display with blanking, sign and overflow.
module result_display #(
  parameter int SCAN_DIV  = 50000,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        show_rem,
  input  logic        clr,
  input  logic [31:0] op_result,
  input  logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic [7:0]  seg,
  output logic [7:0]  dig_sel
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   bcd_q, bcd_d;
  logic [31:0]   mag_q, mag_d;
  logic          neg_q, neg_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   dig_q, dig_d;
  logic          dneg_q, dneg_d;
  logic          dovf_q, dovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    dig_sel_q, dig_sel_d;

  logic [31:0]   value_s;
  logic [31:0]   abs_s;
  logic          is_neg_s;
  logic          ovf_s;
  logic [2:0]    msd_s;
  logic [3:0]    cur_s;

  function automatic logic [31:0] add3(input logic [31:0] b);
    logic [31:0] r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = b[i*4 +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // Operand selection, sign handling and overflow decision at latch time
  always_comb begin
    value_s  = show_rem ? {16'd0, remainder} : op_result;
    is_neg_s = (SIGNED_EN != 1'b0) && !show_rem && op_result[31];
    abs_s    = is_neg_s ? (~value_s + 32'd1) : value_s;
    ovf_s    = (abs_s > 32'd99_999_999) || (is_neg_s && (abs_s > 32'd9_999_999));
  end

  // Conversion FSM and committed display registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    dneg_d  = dneg_q;
    dovf_d  = dovf_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      dig_d   = 32'd0;
      dneg_d  = 1'b0;
      dovf_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CONV;
            cnt_d   = 5'd0;
            bcd_d   = 32'd0;
            mag_d   = abs_s;
            neg_d   = is_neg_s;
            ovf_d   = ovf_s;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CONV: begin
          // Bits shifted out of digit 7 are dropped; overflow is already known.
          {bcd_d, mag_d} = {add3(bcd_q), mag_q} << 1;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CONV;
          end
        end
        S_DONE: begin
          dig_d   = bcd_q;
          dneg_d  = neg_q;
          dovf_d  = ovf_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // Free-running digit scan prescaler and index
  always_comb begin
    if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      pre_d = pre_q + PW'(1);
      idx_d = idx_q;
    end
  end

  // Segment pattern for the currently selected digit
  always_comb begin
    msd_s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (dig_q[i*4 +: 4] != 4'd0) begin
        msd_s = 3'(i);
      end else begin
        msd_s = msd_s;
      end
    end
    cur_s = dig_q[{idx_q, 2'b00} +: 4];
    if (dovf_q) begin
      seg_d = (idx_q == 3'd0) ? 8'h86 : 8'hFF;
    end else if (idx_q <= msd_s) begin
      seg_d = seg_code(cur_s);
    end else if (dneg_q && ({1'b0, idx_q} == ({1'b0, msd_s} + 4'd1))) begin
      seg_d = 8'hBF;
    end else begin
      seg_d = 8'hFF;
    end
    dig_sel_d = ~(8'b0000_0001 << idx_q);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      bcd_q     <= 32'd0;
      mag_q     <= 32'd0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      dig_q     <= 32'd0;
      dneg_q    <= 1'b0;
      dovf_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pre_q     <= '0;
      idx_q     <= 3'd0;
      seg_q     <= 8'hFF;
      dig_sel_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      dig_q     <= dig_d;
      dneg_q    <= dneg_d;
      dovf_q    <= dovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: a signed and an unsigned instance share stimulus;
// displayed digits are collected over a full scan and compared against hand-computed codes.
module tb_result_display;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        show_rem;
  logic        clr;
  logic [31:0] op_result;
  logic [15:0] remainder;
  logic        busy_s, done_s, busy_u, done_u;
  logic [7:0]  seg_s, dig_sel_s, seg_u, dig_sel_u;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int n_done_s;
  int n_done_u;
  logic [63:0] disp_s;
  logic [63:0] disp_u;

  result_display #(.SCAN_DIV(4), .SIGNED_EN(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .show_rem(show_rem), .clr(clr),
    .op_result(op_result), .remainder(remainder),
    .busy(busy_s), .done(done_s), .seg(seg_s), .dig_sel(dig_sel_s)
  );

  result_display #(.SCAN_DIV(4), .SIGNED_EN(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .show_rem(show_rem), .clr(clr),
    .op_result(op_result), .remainder(remainder),
    .busy(busy_u), .done(done_u), .seg(seg_u), .dig_sel(dig_sel_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Collect one full scan of both displays, digit k at disp[k*8 +: 8]
  task automatic read_disp;
    logic [7:0] sel;
    disp_s = 64'd0;
    disp_u = 64'd0;
    for (int t = 0; t < 72; t++) begin
      tick();
      for (int k = 0; k < 8; k++) begin
        sel = ~(8'b0000_0001 << k);
        if (dig_sel_s == sel) disp_s[k*8 +: 8] = seg_s;
        if (dig_sel_u == sel) disp_u[k*8 +: 8] = seg_u;
      end
    end
  endtask

  // Launch a conversion, optionally re-pulse start while busy, count done pulses
  task automatic run(input logic [31:0] v, input logic [15:0] r, input logic sr,
                     input int extra_at);
    op_result = v;
    remainder = r;
    show_rem  = sr;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check("busy_after_start", 64'(busy_s), 64'd1);
    lat      = -1;
    n_done_s = 0;
    n_done_u = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == extra_at) start = 1'b1;
      tick();
      start = 1'b0;
      if (done_s) begin
        n_done_s++;
        if (n_done_s == 1) lat = i;
      end
      if (done_u) n_done_u++;
    end
    check("done_latency", 64'(lat), 64'd33);
    check("done_count_s", 64'(n_done_s), 64'd1);
    check("done_count_u", 64'(n_done_u), 64'd1);
    check("busy_idle", 64'(busy_s), 64'd0);
  endtask

  task automatic no_done_window(input string tag);
    n_done_s = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_s || done_u) n_done_s++;
    end
    check(tag, 64'(n_done_s), 64'd0);
  endtask

  initial begin
    logic [7:0] exp_sel;
    int         waited;
    rst_n     = 1'b0;
    start     = 1'b0;
    show_rem  = 1'b0;
    clr       = 1'b0;
    op_result = 32'd0;
    remainder = 16'd0;
    #12;
    check("rst_seg", 64'(seg_s), 64'hFF);
    check("rst_dig_sel", 64'(dig_sel_s), 64'hFF);
    check("rst_busy_done", 64'({busy_s, done_s}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Scan order after reset
    waited = 0;
    while (dig_sel_s != 8'hFE && waited < 40) begin
      tick();
      waited++;
    end
    check("scan_first_fe", 64'(dig_sel_s), 64'hFE);
    for (int k = 1; k <= 8; k++) begin
      repeat (4) tick();
      exp_sel = ~(8'b0000_0001 << (k % 8));
      check("scan_seq", 64'(dig_sel_s), 64'(exp_sel));
    end
    read_disp();
    check("reset_disp", disp_s, 64'hFFFF_FFFF_FFFF_FFC0);

    run(32'd1234, 16'd0, 1'b0, 0);
    read_disp();
    check("d1234_s", disp_s, 64'hFFFF_FFFF_F9A4_B099);
    check("d1234_u", disp_u, 64'hFFFF_FFFF_F9A4_B099);

    run(32'hFFFF_FFF9, 16'd0, 1'b0, 0);
    read_disp();
    check("neg7_s", disp_s, 64'hFFFF_FFFF_FFFF_BFF8);
    check("neg7_u_ovf", disp_u, 64'hFFFF_FFFF_FFFF_FF86);

    run(32'd99_980_001, 16'd0, 1'b0, 0);
    read_disp();
    check("max8_s", disp_s, 64'h9090_9080_C0C0_C0F9);
    check("max8_u", disp_u, 64'h9090_9080_C0C0_C0F9);

    run(32'd100_000_000, 16'd0, 1'b0, 0);
    read_disp();
    check("ovf9_s", disp_s, 64'hFFFF_FFFF_FFFF_FF86);
    check("ovf9_u", disp_u, 64'hFFFF_FFFF_FFFF_FF86);

    run(32'hFF67_6981, 16'd0, 1'b0, 0);
    read_disp();
    check("neg7nines_s", disp_s, 64'hBF90_9090_9090_9090);
    check("neg7nines_u", disp_u, 64'hFFFF_FFFF_FFFF_FF86);

    run(32'hFF67_6980, 16'd0, 1'b0, 0);
    read_disp();
    check("neg_ovf_s", disp_s, 64'hFFFF_FFFF_FFFF_FF86);

    run(32'h8000_0000, 16'hFFFF, 1'b1, 0);
    read_disp();
    check("rem65535_s", disp_s, 64'hFFFF_FF82_9292_B092);

    run(32'd5, 16'd0, 1'b1, 10);
    read_disp();
    check("rem0_s", disp_s, 64'hFFFF_FFFF_FFFF_FFC0);

    // clr mid-conversion after a nonzero value is on display
    run(32'd1234, 16'd0, 1'b0, 0);
    op_result = 32'd99_980_001;
    show_rem  = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    repeat (14) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", 64'(busy_s), 64'd0);
    no_done_window("clr_no_done");
    read_disp();
    check("clr_disp", disp_s, 64'hFFFF_FFFF_FFFF_FFC0);

    // Asynchronous reset mid-conversion
    run(32'd1234, 16'd0, 1'b0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg", 64'(seg_s), 64'hFF);
    check("arst_dig_sel", 64'(dig_sel_s), 64'hFF);
    check("arst_busy", 64'(busy_s), 64'd0);
    tick();
    rst_n = 1'b1;
    no_done_window("arst_no_done");
    read_disp();
    check("arst_disp", disp_s, 64'hFFFF_FFFF_FFFF_FFC0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
